reg_file_sb: RTL and testbench

//  Architectural register file with write-back merge and pending-write scoreboard.

---
 rtl/reg_file_sb.sv | 167 ++++++++++++++++
 tb/tb_reg_file_sb.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb -- architectural register file with write-back merge and a
// pending-write scoreboard.
//
// Register 0 is hardwired to zero. The WB stage writes through a word, halfword
// or byte merge. Both read ports are combinational and write-first, so a value
// being written back this cycle is forwarded to ID. ID marks a destination
// pending at issue; the matching WB write retires it, and ID stalls while an
// operand is busy.
//
// Ports
//   clk       in   1        rising-edge clock
//   reset     in   1        synchronous, active-high; wins over same-cycle write/set
//   wr_en     in   1        WB write strobe
//   w_mode    in   2        0=word, 1=halfword, 2=byte, 3=reserved (no store)
//   Addr      in   WIDTH    WB destination, only Addr[AW-1:0] is used
//   Data      in   WIDTH    WB write data
//   rs_addr   in   AW       read port A index
//   rt_addr   in   AW       read port B index
//   rs_data   out  WIDTH    read port A data (combinational, bypassed)
//   rt_data   out  WIDTH    read port B data (combinational, bypassed)
//   set_en    in   1        ID issue strobe: mark set_addr pending
//   set_addr  in   AW       destination being issued
//   rs_busy   out  1        rs_addr has an outstanding write
//   rt_busy   out  1        rt_addr has an outstanding write
//   pend_cnt  out  AW+1     number of pending registers (registered counter)
module reg_file_sb #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [1:0]       w_mode,
  input  logic [WIDTH-1:0] Addr,
  input  logic [WIDTH-1:0] Data,
  input  logic [AW-1:0]    rs_addr,
  input  logic [AW-1:0]    rt_addr,
  output logic [WIDTH-1:0] rs_data,
  output logic [WIDTH-1:0] rt_data,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  output logic             rs_busy,
  output logic             rt_busy,
  output logic [AW:0]      pend_cnt
);

  // Lane merge shared by the array write and the read bypass, so both always
  // agree on what gets stored.
  function automatic logic [WIDTH-1:0] merge_word(
    input logic [WIDTH-1:0] old_v,
    input logic [WIDTH-1:0] new_v,
    input logic [1:0]       mode
  );
    case (mode)
      2'd0:    merge_word = new_v;
      2'd1:    merge_word = {old_v[WIDTH-1:16], new_v[15:0]};
      2'd2:    merge_word = {old_v[WIDTH-1:8], new_v[7:0]};
      default: merge_word = old_v;
    endcase
  endfunction

  logic [WIDTH-1:0] regs_r [NREGS];
  logic [NREGS-1:0] pend_r;
  logic [AW:0]      cnt_r;

  logic [AW-1:0]    idx_s;
  logic             wr_hit_s;     // write strobe to a real register (any mode)
  logic             wr_store_s;   // write that actually changes the array
  logic [WIDTH-1:0] merged_s;
  logic [NREGS-1:0] set_vec_s;
  logic [NREGS-1:0] clr_vec_s;
  logic [NREGS-1:0] pend_next_s;
  logic             inc_s;
  logic             dec_s;
  logic             unused_addr_s;

  assign idx_s         = Addr[AW-1:0];
  assign unused_addr_s = ^Addr[WIDTH-1:AW];
  assign wr_hit_s      = wr_en && (idx_s != {AW{1'b0}});
  assign wr_store_s    = wr_hit_s && (w_mode != 2'd3);
  assign merged_s      = merge_word(regs_r[idx_s], Data, w_mode);

  // Register array: reset clears everything, otherwise store the merged word.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_store_s) begin
      regs_r[idx_s] <= merged_s;
    end
  end

  // Read ports with write-first bypass; register 0 always reads as zero.
  always_comb begin
    rs_data = regs_r[rs_addr];
    rt_data = regs_r[rt_addr];
    if (rs_addr == {AW{1'b0}}) begin
      rs_data = {WIDTH{1'b0}};
    end else if (wr_store_s && (idx_s == rs_addr)) begin
      rs_data = merged_s;
    end else begin
      rs_data = regs_r[rs_addr];
    end
    if (rt_addr == {AW{1'b0}}) begin
      rt_data = {WIDTH{1'b0}};
    end else if (wr_store_s && (idx_s == rt_addr)) begin
      rt_data = merged_s;
    end else begin
      rt_data = regs_r[rt_addr];
    end
  end

  // One-hot set/clear vectors; bit 0 is never set or cleared, so it stays 0.
  always_comb begin
    set_vec_s = {NREGS{1'b0}};
    clr_vec_s = {NREGS{1'b0}};
    for (int i = 1; i < NREGS; i++) begin
      set_vec_s[i] = set_en   && (set_addr == AW'(i));
      clr_vec_s[i] = wr_hit_s && (idx_s == AW'(i));
    end
  end

  // Set is applied after clear so a same-cycle set on the retiring reg wins.
  assign pend_next_s = (pend_r & ~clr_vec_s) | set_vec_s;

  // Counter deltas mirror exactly the bits that change 0->1 and 1->0.
  assign inc_s = set_vec_s[set_addr] && !pend_r[set_addr];
  assign dec_s = clr_vec_s[idx_s] && pend_r[idx_s] && !set_vec_s[idx_s];

  // Scoreboard bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_r <= {NREGS{1'b0}};
    end else begin
      pend_r <= pend_next_s;
    end
  end

  // Pending counter: saturates at NREGS-1 and never wraps below zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {(AW+1){1'b0}};
    end else begin
      case ({inc_s, dec_s})
        2'b10: begin
          if (cnt_r != (AW+1)'(NREGS-1)) begin
            cnt_r <= cnt_r + {{AW{1'b0}}, 1'b1};
          end
        end
        2'b01: begin
          if (cnt_r != {(AW+1){1'b0}}) begin
            cnt_r <= cnt_r - {{AW{1'b0}}, 1'b1};
          end
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Operand being written back this cycle is forwarded, hence not busy.
  assign rs_busy  = pend_r[rs_addr] && !(wr_en && (idx_s == rs_addr));
  assign rt_busy  = pend_r[rt_addr] && !(wr_en && (idx_s == rt_addr));
  assign pend_cnt = cnt_r;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a behavioural model predicts every output, expected
// values are queued when a cycle is driven and popped against the DUT at the
// following negative clock edge.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [1:0]  w_mode;
  logic [31:0] Addr;
  logic [31:0] Data;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        set_en;
  logic [4:0]  set_addr;
  logic        rs_busy;
  logic        rt_busy;
  logic [5:0]  pend_cnt;

  reg_file_sb #(.WIDTH(32), .NREGS(32), .AW(5)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .w_mode(w_mode), .Addr(Addr),
    .Data(Data), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data),
    .rt_data(rt_data), .set_en(set_en), .set_addr(set_addr), .rs_busy(rs_busy),
    .rt_busy(rt_busy), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_pend;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  logic        lit_en  = 1'b0;
  logic [31:0] lit_val = 32'h0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [1:0] m);
    if (m == 2'd0)      return 32'hFFFF_FFFF;
    else if (m == 2'd1) return 32'h0000_FFFF;
    else if (m == 2'd2) return 32'h0000_00FF;
    else                return 32'h0000_0000;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] mk;
    if (a == 5'd0) return 32'h0;
    mk = lane_mask(w_mode);
    if (wr_en && (Addr[4:0] == a)) return (m_regs[a] & ~mk) | (Data & mk);
    return m_regs[a];
  endfunction

  function automatic logic m_busy(input logic [4:0] a);
    return m_pend[a] && !(wr_en && (Addr[4:0] == a));
  endfunction

  // Drive one cycle, queue predictions, compare at negedge, then advance the model.
  task automatic cycle(input logic rst, input logic we, input logic [1:0] wm,
                       input logic [31:0] ad, input logic [31:0] dt,
                       input logic [4:0] ra, input logic [4:0] rb,
                       input logic se, input logic [4:0] sa);
    logic [31:0] obs [6];
    logic [4:0]  ix;
    logic [31:0] mk;
    reset = rst; wr_en = we; w_mode = wm; Addr = ad; Data = dt;
    rs_addr = ra; rt_addr = rb; set_en = se; set_addr = sa;
    exp_q.push_back(m_read(ra));                   tag_q.push_back("rs_data");
    exp_q.push_back(m_read(rb));                   tag_q.push_back("rt_data");
    exp_q.push_back({31'h0, m_busy(ra)});          tag_q.push_back("rs_busy");
    exp_q.push_back({31'h0, m_busy(rb)});          tag_q.push_back("rt_busy");
    exp_q.push_back(32'($countones(m_pend)));      tag_q.push_back("pend_cnt");
    if (lit_en) begin
      exp_q.push_back(lit_val);                    tag_q.push_back("rs_literal");
    end
    @(negedge clk);
    obs[0] = rs_data; obs[1] = rt_data; obs[2] = {31'h0, rs_busy};
    obs[3] = {31'h0, rt_busy}; obs[4] = {26'h0, pend_cnt}; obs[5] = rs_data;
    for (int k = 0; k < 6 && exp_q.size() > 0; k++) begin
      check_val(tag_q.pop_front(), obs[k], exp_q.pop_front());
    end
    lit_en = 1'b0;
    @(posedge clk);
    ix = ad[4:0];
    if (rst) begin
      for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
      m_pend = 32'h0;
    end else begin
      mk = lane_mask(wm);
      if (we && ix != 5'd0) begin
        m_regs[ix] = (m_regs[ix] & ~mk) | (dt & mk);
        m_pend[ix] = 1'b0;
      end
      if (se && sa != 5'd0) m_pend[sa] = 1'b1;
    end
    #1;
  endtask

  task automatic lit(input logic [31:0] v);
    lit_en = 1'b1; lit_val = v;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; w_mode = 2'd0; Addr = 32'h0; Data = 32'h0;
    rs_addr = 5'd0; rt_addr = 5'd0; set_en = 1'b0; set_addr = 5'd0;
    for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
    m_pend = 32'h0;
    @(posedge clk); @(posedge clk); #1;

    // 1: dirty state, then reset
    cycle(0, 1, 2'd0, 32'd1, 32'h1111_1111, 5'd1, 5'd2, 1, 5'd10);
    cycle(0, 1, 2'd0, 32'd2, 32'h2222_2222, 5'd1, 5'd10, 1, 5'd11);
    cycle(1, 1, 2'd0, 32'd3, 32'h3333_3333, 5'd1, 5'd10, 1, 5'd12);
    lit(32'h0);
    cycle(0, 0, 2'd0, 32'd0, 32'h0, 5'd1, 5'd10, 0, 5'd0);

    // 2: word write with same-cycle bypass, then from the array
    lit(32'hDEAD_BEEF);
    cycle(0, 1, 2'd0, 32'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 0, 5'd0);
    lit(32'hDEAD_BEEF);
    cycle(0, 0, 2'd0, 32'd0, 32'h0, 5'd5, 5'd0, 0, 5'd0);

    // 3: halfword, byte (upper Addr bits ignored), reserved mode
    lit(32'hDEAD_1234);
    cycle(0, 1, 2'd1, 32'd5, 32'h0000_1234, 5'd5, 5'd5, 0, 5'd0);
    lit(32'hDEAD_12FF);
    cycle(0, 1, 2'd2, 32'hFFFF_FFE5, 32'h0000_00FF, 5'd5, 5'd5, 0, 5'd0);
    lit(32'hDEAD_12FF);
    cycle(0, 1, 2'd3, 32'd5, 32'h5555_5555, 5'd5, 5'd5, 0, 5'd0);
    lit(32'hDEAD_12FF);
    cycle(0, 0, 2'd0, 32'd0, 32'h0, 5'd5, 5'd0, 0, 5'd0);

    // 4: register 0 write and set are ignored
    lit(32'h0);
    cycle(0, 1, 2'd0, 32'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1, 5'd0);
    lit(32'h0);
    cycle(0, 0, 2'd0, 32'd0, 32'h0, 5'd0, 5'd0, 0, 5'd0);

    // 5: set/retire of reg 7, then set and retire in the same cycle
    cycle(0, 0, 2'd0, 32'd0, 32'h0, 5'd7, 5'd0, 1, 5'd7);
    cycle(0, 0, 2'd0, 32'd0, 32'h0, 5'd7, 5'd7, 0, 5'd0);
    lit(32'h0000_0077);
    cycle(0, 1, 2'd0, 32'd7, 32'h0000_0077, 5'd7, 5'd7, 0, 5'd0);
    cycle(0, 0, 2'd0, 32'd0, 32'h0, 5'd7, 5'd0, 0, 5'd0);
    cycle(0, 1, 2'd0, 32'd7, 32'h0000_0088, 5'd7, 5'd0, 1, 5'd7);
    cycle(0, 0, 2'd0, 32'd0, 32'h0, 5'd7, 5'd7, 0, 5'd0);
    cycle(0, 1, 2'd3, 32'd7, 32'h0, 5'd7, 5'd7, 0, 5'd0);
    cycle(0, 0, 2'd0, 32'd0, 32'h0, 5'd7, 5'd0, 0, 5'd0);

    // 6: duplicate set, retire of a non-pending reg, reset beating a write
    cycle(0, 0, 2'd0, 32'd0, 32'h0, 5'd3, 5'd4, 1, 5'd3);
    cycle(0, 0, 2'd0, 32'd0, 32'h0, 5'd3, 5'd4, 1, 5'd4);
    cycle(0, 0, 2'd0, 32'd0, 32'h0, 5'd3, 5'd4, 1, 5'd3);
    cycle(0, 1, 2'd0, 32'd9, 32'h0000_0009, 5'd9, 5'd3, 0, 5'd0);
    cycle(0, 0, 2'd0, 32'd0, 32'h0, 5'd9, 5'd3, 0, 5'd0);
    cycle(1, 1, 2'd0, 32'd3, 32'h3333_3333, 5'd3, 5'd4, 0, 5'd0);
    lit(32'h0);
    cycle(0, 0, 2'd0, 32'd0, 32'h0, 5'd3, 5'd4, 0, 5'd0);

    // Random mix
    for (int n = 0; n < 150; n++) begin
      cycle(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), {$urandom, 5'($urandom_range(0, 31))} >> 0,
            $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
